// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks pending register writes, interlocks decode, bounds in-flight work and sequences drains.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rd_we_i,
  output logic             id_ready_o,
  output logic             issue_o,
  output logic             stall_o,
  input  logic             wb_valid_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  output logic [31:0]      busy_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic             draining_o,
  output logic             err_o
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [31:0]      busy_q, busy_d, set_vec, clr_vec;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             err_q;
  logic             raw_hz, waw_hz, room, wb_ok;

  // Hazards look only at registered busy; bit 0 is never set, so x0 cannot stall
  always_comb begin
    raw_hz     = (id_rs1_used_i & busy_q[id_rs1_i]) | (id_rs2_used_i & busy_q[id_rs2_i]);
    waw_hz     = id_rd_we_i & busy_q[id_rd_i];
    room       = (inflight_q < CNT_W'(MAX_INFLIGHT));
    id_ready_o = (state_q == RUN) & ~flush_i & ~raw_hz & ~waw_hz & room;
  end

  assign issue_o = id_valid_i & id_ready_o;
  assign stall_o = id_valid_i & ~id_ready_o;

  // A retirement with nothing in flight is an error and must not disturb state
  assign wb_ok = wb_valid_i & (inflight_q != '0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_o && id_rd_we_i && (id_rd_i != 5'd0)) set_vec[id_rd_i] = 1'b1;
    if (wb_ok && wb_we_i && (wb_rd_i != 5'd0))      clr_vec[wb_rd_i] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_o, wb_ok})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      if (wb_valid_i && (inflight_q == '0)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_i) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && !flush_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    draining_o = (state_q == DRAIN);
  end

  assign busy_o     = busy_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule
